hazard_ctrl: RTL and testbench

Central pipeline control unit for the 5-stage RISC-V core. Generates the stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers from three hazard sources:
- load-use data hazards,
- taken branches/jumps resolved in EX,
- data-memory wait states.
A small FSM tracks multi-cycle data-memory accesses and contains a watchdog timeout that halts the core on a hung bus.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, EX redirect flush, dmem wait freeze and watchdog halt.
// Define PERF_CNT_EN to add saturating stall/redirect performance counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_redirect_i,
    input  logic             mem_access_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             pc_redirect_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic             mem_wb_flush_o,
    output logic             dmem_timeout_o,
    output logic [1:0]       state_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic mem_busy;
    logic halted;
    logic freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Hazard detection
    always_comb begin
        mem_busy = mem_access_i & ~dmem_ready_i;
        halted   = (state_q == HALT);
        freeze   = halted | (mem_busy & ((state_q == RUN) | (state_q == MEM_WAIT)));
        rs1_hit  = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit  = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
        load_use = ex_mem_read_i & (ex_rd_addr_i != '0) & (rs1_hit | rs2_hit);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic; the wait counter counts stalled cycles of the current access
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output logic: halt/freeze > redirect > load-use
    always_comb begin
        pc_stall_o     = 1'b0;
        pc_redirect_o  = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (ex_redirect_i) begin
                pc_redirect_o = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    assign state_o        = state_q;
    assign dmem_timeout_o = timeout_q;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (pc_stall_o && (perf_stall_cnt_o != '1)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + CNT_W'(1);
            end
            if (pc_redirect_o && (perf_flush_cnt_o != '1)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4); perf counters checked when PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       ma;
        logic       rdy;
    } stim_t;

    // {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1010_0100;
    localparam logic [7:0] RD   = 8'b0101_0100;
    localparam logic [7:0] FRZ  = 8'b1010_1011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic       id_uses_rs1_i, id_uses_rs2_i, ex_mem_read_i, ex_redirect_i;
    logic       mem_access_i, dmem_ready_i;
    logic       pc_stall_o, pc_redirect_o, if_id_stall_o, if_id_flush_o;
    logic       id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o;
    logic       dmem_timeout_o;
    logic [1:0] state_o;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;
    logic [10:0] obs;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_uses_rs1_i   (id_uses_rs1_i),
        .id_uses_rs2_i   (id_uses_rs2_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_mem_read_i   (ex_mem_read_i),
        .ex_redirect_i   (ex_redirect_i),
        .mem_access_i    (mem_access_i),
        .dmem_ready_i    (dmem_ready_i),
        .pc_stall_o      (pc_stall_o),
        .pc_redirect_o   (pc_redirect_o),
        .if_id_stall_o   (if_id_stall_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_stall_o   (id_ex_stall_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .ex_mem_stall_o  (ex_mem_stall_o),
        .mem_wb_flush_o  (mem_wb_flush_o),
        .dmem_timeout_o  (dmem_timeout_o),
        .state_o         (state_o)
`ifdef PERF_CNT_EN
        ,
        .perf_stall_cnt_o(perf_stall_cnt_o),
        .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    assign obs = {pc_stall_o, pc_redirect_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                  id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, dmem_timeout_o, state_o};

    function automatic stim_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic ma, input logic rdy);
        stim_t s;
        s = '{rst: r, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr, redir: redir, ma: ma, rdy: rdy};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_n         = s.rst;
        id_rs1_addr_i = s.rs1;
        id_rs2_addr_i = s.rs2;
        id_uses_rs1_i = s.u1;
        id_uses_rs2_i = s.u2;
        ex_rd_addr_i  = s.rd;
        ex_mem_read_i = s.mr;
        ex_redirect_i = s.redir;
        mem_access_i  = s.ma;
        dmem_ready_i  = s.rdy;
    endtask

    task automatic test_reset();
        stim_t s[3];
        logic [10:0] e[3];
        s[0] = mk(0, 3, 5, 1, 1, 5, 1, 1, 1, 0); e[0] = {NONE, 1'b0, 2'd0};
        s[1] = mk(0, 3, 5, 1, 1, 5, 1, 1, 1, 0); e[1] = {NONE, 1'b0, 2'd0};
        s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = {NONE, 1'b0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL reset[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        logic [10:0] e[6];
        s[0] = mk(1, 0, 5, 0, 1, 5, 1, 0, 0, 0); e[0] = {LU,   1'b0, 2'd0};
        s[1] = mk(1, 0, 5, 0, 1, 5, 0, 0, 0, 0); e[1] = {NONE, 1'b0, 2'd0};
        s[2] = mk(1, 7, 0, 1, 0, 7, 1, 0, 0, 0); e[2] = {LU,   1'b0, 2'd0};
        s[3] = mk(1, 7, 7, 0, 0, 7, 1, 0, 0, 0); e[3] = {NONE, 1'b0, 2'd0};
        s[4] = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0); e[4] = {NONE, 1'b0, 2'd0};
        s[5] = mk(1, 5, 9, 1, 1, 9, 1, 0, 0, 0); e[5] = {LU,   1'b0, 2'd0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL load_use[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_redirect();
        stim_t s[3];
        logic [10:0] e[3];
        s[0] = mk(1, 0, 5, 0, 1, 5, 1, 1, 0, 0); e[0] = {RD,   1'b0, 2'd0};
        s[1] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[1] = {RD,   1'b0, 2'd0};
        s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = {NONE, 1'b0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL redirect[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[10];
        logic [10:0] e[10];
        s[0] = mk(1, 0, 5, 0, 1, 5, 1, 0, 1, 0); e[0] = {FRZ,  1'b0, 2'd0};
        s[1] = mk(1, 0, 5, 0, 1, 5, 1, 0, 1, 0); e[1] = {FRZ,  1'b0, 2'd1};
        s[2] = mk(1, 0, 5, 0, 1, 5, 1, 0, 1, 0); e[2] = {FRZ,  1'b0, 2'd1};
        s[3] = mk(1, 0, 5, 0, 1, 5, 1, 0, 1, 1); e[3] = {LU,   1'b0, 2'd1};
        s[4] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = {NONE, 1'b0, 2'd0};
        s[5] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); e[5] = {NONE, 1'b0, 2'd0};
        s[6] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[6] = {NONE, 1'b0, 2'd0};
        s[7] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); e[7] = {FRZ,  1'b0, 2'd0};
        s[8] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1); e[8] = {RD,   1'b0, 2'd1};
        s[9] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[9] = {NONE, 1'b0, 2'd0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL mem_wait[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s[9];
        logic [10:0] e[9];
        s[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[0] = {FRZ,  1'b0, 2'd0};
        s[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[1] = {FRZ,  1'b0, 2'd1};
        s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[2] = {FRZ,  1'b0, 2'd1};
        s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[3] = {FRZ,  1'b0, 2'd1};
        s[4] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[4] = {FRZ,  1'b1, 2'd2};
        s[5] = mk(1, 0, 5, 0, 1, 5, 1, 1, 1, 1); e[5] = {FRZ,  1'b1, 2'd2};
        s[6] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[6] = {FRZ,  1'b1, 2'd2};
        s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[7] = {NONE, 1'b0, 2'd0};
        s[8] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[8] = {NONE, 1'b0, 2'd0};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL timeout[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[6];
        logic [10:0] e[6];
        s[0] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[0] = {RD,   1'b0, 2'd0};
        s[1] = mk(1, 3, 0, 1, 0, 3, 1, 0, 0, 0); e[1] = {LU,   1'b0, 2'd0};
        s[2] = mk(1, 0, 4, 0, 1, 4, 1, 0, 0, 0); e[2] = {LU,   1'b0, 2'd0};
        s[3] = mk(1, 4, 0, 1, 0, 4, 1, 1, 1, 0); e[3] = {FRZ,  1'b0, 2'd0};
        s[4] = mk(1, 4, 0, 1, 0, 4, 1, 1, 1, 1); e[4] = {RD,   1'b0, 2'd1};
        s[5] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = {NONE, 1'b0, 2'd0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                $display("FAIL back_to_back[%0d] got %b expected %b", i, obs, exp_v);
                miscompares++;
            end
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf();
        stim_t s[5];
        logic [10:0] e[5];
        logic [CNT_W-1:0] ps_exp[5];
        logic [CNT_W-1:0] pf_exp[5];
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[0] = {NONE, 1'b0, 2'd0}; ps_exp[0] = 0; pf_exp[0] = 0;
        s[1] = mk(1, 0, 5, 0, 1, 5, 1, 0, 0, 0); e[1] = {LU,   1'b0, 2'd0}; ps_exp[1] = 0; pf_exp[1] = 0;
        s[2] = mk(1, 6, 0, 1, 0, 6, 1, 0, 0, 0); e[2] = {LU,   1'b0, 2'd0}; ps_exp[2] = 1; pf_exp[2] = 0;
        s[3] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[3] = {RD,   1'b0, 2'd0}; ps_exp[3] = 2; pf_exp[3] = 0;
        s[4] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = {NONE, 1'b0, 2'd0}; ps_exp[4] = 2; pf_exp[4] = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            vectors++;
            if (obs !== exp_v || perf_stall_cnt_o !== ps_exp[i] || perf_flush_cnt_o !== pf_exp[i]) begin
                $display("FAIL perf[%0d] got %b stall=%0d flush=%0d expected %b stall=%0d flush=%0d",
                         i, obs, perf_stall_cnt_o, perf_flush_cnt_o, exp_v, ps_exp[i], pf_exp[i]);
                miscompares++;
            end
        end
    endtask
`endif

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
`ifdef PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
